f1_light_seq: RTL and testbench



---
 rtl/f1_light_seq.sv | 128 ++++++++++++
 tb/tb_f1_light_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/f1_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : f1_light_seq
// Brief    : Start-light sequencer: fills N lights one per tick after a
//            trigger, holds them for a programmable tick count, then blanks
//            them with a one-cycle lights_out pulse. Optional macro
//            F1_JUMP_START_EN adds a sticky jump_start abort on trigger in HOLD.
// Revision : 1.0  initial release
// ============================================================================
module f1_light_seq #(
    parameter int N_LIGHTS = 8,
    parameter int DELAY_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                tick,
    input  logic [DELAY_W-1:0]  delay_in,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
`ifdef F1_JUMP_START_EN
    output logic                jump_start,
`endif
    output logic                lights_out
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    localparam logic [DELAY_W-1:0] c_ONE = DELAY_W'(1);

    logic [1:0]          state_q, state_d;
    logic [N_LIGHTS-1:0] data_q,  data_d;
    logic [DELAY_W-1:0]  cnt_q,   cnt_d;
    logic                lo_q,    lo_d;
`ifdef F1_JUMP_START_EN
    logic                js_q,    js_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        lo_d    = 1'b0;
`ifdef F1_JUMP_START_EN
        js_d    = js_q;
`endif
        case (state_q)
            c_IDLE: begin
                data_d = '0;
                if (trigger) begin
                    state_d = c_FILL;
`ifdef F1_JUMP_START_EN
                    js_d    = 1'b0;
`endif
                end
            end
            c_FILL: begin
                if (tick) begin
                    data_d = {data_q[N_LIGHTS-2:0], 1'b1};
                    // Last shift lights the final bit; latch the hold length now.
                    if (&data_q[N_LIGHTS-2:0]) begin
                        state_d = c_HOLD;
                        cnt_d   = (delay_in == '0) ? c_ONE : delay_in;
                    end
                end
            end
            c_HOLD: begin
`ifdef F1_JUMP_START_EN
                if (trigger) begin
                    state_d = c_IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                    js_d    = 1'b1;
                end else
`endif
                if (tick) begin
                    if (cnt_q == c_ONE) begin
                        state_d = c_OUT;
                        data_d  = '0;
                        lo_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - c_ONE;
                    end
                end
            end
            c_OUT: begin
                state_d = c_IDLE;
                data_d  = '0;
            end
            default: begin
                state_d = c_IDLE;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= 1'b0;
`ifdef F1_JUMP_START_EN
            js_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
`ifdef F1_JUMP_START_EN
            js_q    <= js_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign lights_out = lo_q;
    assign busy       = (state_q != c_IDLE);
`ifdef F1_JUMP_START_EN
    assign jump_start = js_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f1_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_f1_light_seq
// Brief    : Self-checking bench for f1_light_seq: vector table, directed
//            corner sequences and random stimulus against a tick-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_f1_light_seq;

    localparam int N_LIGHTS = 8;
    localparam int DELAY_W  = 7;
`ifdef F1_JUMP_START_EN
    localparam bit JS_EN = 1'b1;
`else
    localparam bit JS_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                trigger = 1'b0;
    logic                tick = 1'b0;
    logic [DELAY_W-1:0]  delay_in = '0;
    logic [N_LIGHTS-1:0] data_out;
    logic                busy;
    logic                lights_out;
    logic                jump_start;

    int tests  = 0;
    int errors = 0;

    f1_light_seq #(.N_LIGHTS(N_LIGHTS), .DELAY_W(DELAY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .tick       (tick),
        .delay_in   (delay_in),
        .data_out   (data_out),
        .busy       (busy),
`ifdef F1_JUMP_START_EN
        .jump_start (jump_start),
`endif
        .lights_out (lights_out)
    );
`ifndef F1_JUMP_START_EN
    assign jump_start = 1'b0;
`endif

    always #5 clk = ~clk;

    // Model: a sequence is "ticks counted since trigger"; lights = min(t,N),
    // hold ends when t reaches N + max(delay,1).
    bit m_run = 0, m_out = 0, m_js = 0;
    int m_t = 0, m_d = 1;

    task automatic model_update();
        if (rst) begin
            m_run = 0; m_out = 0; m_t = 0; m_js = 0;
        end else if (m_out) begin
            m_out = 0;
        end else if (!m_run) begin
            if (trigger) begin
                m_run = 1; m_t = 0; m_js = 0;
            end
        end else if (JS_EN && trigger && m_t >= N_LIGHTS) begin
            m_run = 0; m_js = 1;
        end else if (tick) begin
            m_t = m_t + 1;
            if (m_t == N_LIGHTS)
                m_d = (delay_in == 0) ? 1 : int'(delay_in);
            else if (m_t > N_LIGHTS && m_t == N_LIGHTS + m_d) begin
                m_run = 0; m_out = 1;
            end
        end
    endtask

    function automatic logic [N_LIGHTS+2:0] model_exp();
        logic [N_LIGHTS-1:0] d;
        int lit;
        lit = (m_t < N_LIGHTS) ? m_t : N_LIGHTS;
        d = '0;
        if (m_run)
            for (int i = 0; i < lit; i++) d[i] = 1'b1;
        return {d, m_run | m_out, m_out, m_js};
    endfunction

    task automatic check(input string name, input logic [N_LIGHTS+2:0] act,
                         input logic [N_LIGHTS+2:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got data=%h busy=%b lo=%b js=%b, expected data=%h busy=%b lo=%b js=%b",
                     name, act[N_LIGHTS+2:3], act[2], act[1], act[0],
                     exp[N_LIGHTS+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock: drive inputs, clock, advance model, compare 1 ns after edge.
    task automatic step(input string name, input logic r, input logic tg,
                        input logic tk, input logic [DELAY_W-1:0] d);
        rst = r; trigger = tg; tick = tk; delay_in = d;
        @(posedge clk);
        model_update();
        #1;
        check(name, {data_out, busy, lights_out, jump_start}, model_exp());
    endtask

    typedef struct {
        logic                rst, trig, tick;
        logic [DELAY_W-1:0]  dly;
        logic [N_LIGHTS-1:0] data;
        logic                busy, lo;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1, 0, 1, 7'd2, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 1, 7'd2, 8'h00, 0, 0};
        tbl[2]  = '{0, 0, 1, 7'd2, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 1, 7'd2, 8'h00, 1, 0};
        tbl[4]  = '{0, 0, 1, 7'd2, 8'h01, 1, 0};
        tbl[5]  = '{0, 0, 1, 7'd2, 8'h03, 1, 0};
        tbl[6]  = '{0, 0, 1, 7'd2, 8'h07, 1, 0};
        tbl[7]  = '{0, 0, 1, 7'd2, 8'h0F, 1, 0};
        tbl[8]  = '{0, 0, 1, 7'd2, 8'h1F, 1, 0};
        tbl[9]  = '{0, 0, 1, 7'd2, 8'h3F, 1, 0};
        tbl[10] = '{0, 0, 1, 7'd2, 8'h7F, 1, 0};
        tbl[11] = '{0, 0, 1, 7'd2, 8'hFF, 1, 0};
        tbl[12] = '{0, 0, 1, 7'd2, 8'hFF, 1, 0};
        tbl[13] = '{0, 0, 1, 7'd2, 8'h00, 1, 1};
        tbl[14] = '{0, 0, 1, 7'd2, 8'h00, 0, 0};
        tbl[15] = '{0, 1, 0, 7'd2, 8'h00, 1, 0};
        tbl[16] = '{0, 1, 1, 7'd2, 8'h01, 1, 0};
        tbl[17] = '{1, 0, 0, 7'd2, 8'h00, 0, 0};

        for (int i = 0; i < 18; i++) begin
            step("table_model", tbl[i].rst, tbl[i].trig, tbl[i].tick, tbl[i].dly);
            check($sformatf("table[%0d]", i), {data_out, busy, lights_out, 1'b0},
                  {tbl[i].data, tbl[i].busy, tbl[i].lo, 1'b0});
        end

        // Tick every 4th cycle, hold 3 ticks.
        for (int i = 0; i < 60; i++)
            step("slow_tick", 0, i == 0, (i % 4) == 3, 7'd3);

        // Zero delay clamps to a single hold tick.
        for (int i = 0; i < 14; i++)
            step("delay_zero", 0, i == 0, 1, 7'd0);
        check("delay_zero_idle", {8'h00, busy, lights_out, 1'b0}, {8'h00, 1'b0, 1'b0, 1'b0});

        // Maximum delay must not wrap; delay_in changes after HOLD entry ignored.
        for (int i = 0; i < 140; i++)
            step("delay_max", 0, i == 0, 1, (i < 10) ? 7'd127 : 7'd1);
        check("delay_max_idle", {8'h00, busy, lights_out, 1'b0}, {8'h00, 1'b0, 1'b0, 1'b0});

        // Reset while lights are held.
        for (int i = 0; i < 12; i++)
            step("pre_rst_hold", 0, i == 0, 1, 7'd10);
        check("in_hold", {data_out, busy, 1'b0, 1'b0}, {8'hFF, 1'b1, 1'b0, 1'b0});
        step("rst_in_hold", 1, 0, 1, 7'd10);
        for (int i = 0; i < 3; i++)
            step("post_rst", 0, 0, 1, 7'd10);

        // Trigger during HOLD: abort with jump_start, or ignored without it.
        for (int i = 0; i < 11; i++)
            step("pre_jump", 0, i == 0, 1, 7'd5);
        step("jump_trig", 0, 1, 0, 7'd5);
        for (int i = 0; i < 8; i++)
            step("after_jump", 0, 0, 1, 7'd5);
        step("retrig_clear", 0, 1, 0, 7'd5);
        step("rst_end", 1, 0, 0, 7'd5);

        for (int i = 0; i < 3000; i++)
            step("random", ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1, DELAY_W'($urandom_range(0, 9)));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
